// File: rtl/wb_arbiter_pkg.sv
// Shared write-back definitions: register bus widths, load funct3 codes, the
// buffered result payload and the load alignment/extension helper.
package wb_arbiter_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    typedef logic [REG_W-1:0]      reg_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_bus_t ZERO_WORD = '0;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        reg_addr_t rd;
        reg_bus_t  data;
    } wb_entry_t;

    // Codes outside the five load types fall through to a plain word load.
    function automatic reg_bus_t load_extend(input reg_bus_t word, input logic [2:0] funct3,
                                             input logic [1:0] off);
        reg_bus_t sh;
        sh = word >> {off, 3'b000};
        case (funct3)
            F3_LB:   load_extend = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   load_extend = {{16{sh[15]}}, sh[15:0]};
            F3_LBU:  load_extend = {24'b0, sh[7:0]};
            F3_LHU:  load_extend = {16'b0, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering ALU results ahead of write-back; supports push and
// pop in the same cycle even when full, and a synchronous clear.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: loads win over buffered ALU results, one regfile write per
// cycle, plus a per-register pending-write scoreboard. Optional WB_COMMIT_CNT_EN adds instret.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int SB_CNT_W   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic        busy1,
    output logic        busy2,
    output logic        iss_full,
    output logic        sb_err,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
`ifdef WB_COMMIT_CNT_EN
    ,
    output logic [63:0] instret
`endif
);

    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

    wb_entry_t fifo_head, sel;
    logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic      sel_valid, commit;

    assign alu_ready = !fifo_full || flush;
    assign fifo_push = alu_valid && alu_ready && !flush;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(wb_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({alu_rd, alu_data}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        fifo_pop  = 1'b0;
        if (!flush) begin
            if (ld_valid) begin
                sel_valid = 1'b1;
                sel.rd    = ld_rd;
                sel.data  = load_extend(ld_data, ld_funct3, ld_off);
            end else if (!fifo_empty) begin
                sel_valid = 1'b1;
                sel       = fifo_head;
                fifo_pop  = 1'b1;
            end
        end
    end

    assign commit = sel_valid && (sel.rd != '0);

    logic      we_q;
    reg_addr_t waddr_q;
    reg_bus_t  wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= ZERO_WORD;
        end else begin
            we_q <= commit;
            if (sel_valid) begin
                waddr_q <= sel.rd;
                wdata_q <= sel.data;
            end
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    // Scoreboard: r0 never sees an increment or decrement, so its counter stays 0.
    logic [SB_CNT_W-1:0] cnt_q [REG_NUM];
    logic [SB_CNT_W-1:0] cnt_d [REG_NUM];
    logic                sb_err_q, sb_err_d;
    logic [REG_NUM-1:0]  inc_vec, dec_vec;

    assign inc_vec = (iss_valid && iss_rd != '0) ? (REG_NUM'(1) << iss_rd) : '0;
    assign dec_vec = commit ? (REG_NUM'(1) << sel.rd) : '0;

    always_comb begin
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        for (int i = 0; i < REG_NUM; i++) begin
            if (flush) begin
                cnt_d[i] = '0;
            end else if (inc_vec[i] && !dec_vec[i]) begin
                if (cnt_q[i] == CNT_MAX) sb_err_d = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + SB_CNT_W'(1);
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (cnt_q[i] == '0) sb_err_d = 1'b1;
                else                cnt_d[i] = cnt_q[i] - SB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= '0;
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign busy1    = (raddr1 != '0) && (cnt_q[raddr1] != '0);
    assign busy2    = (raddr2 != '0) && (cnt_q[raddr2] != '0);
    assign iss_full = (cnt_q[iss_rd] == CNT_MAX);
    assign sb_err   = sb_err_q;

`ifdef WB_COMMIT_CNT_EN
    // Counts every selected result, rd==0 included; flush leaves it untouched.
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst)            instret_q <= '0;
        else if (sel_valid) instret_q <= instret_q + 64'd1;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios followed by random traffic,
// all checked against a queue/array reference model of the write-back rules.
module tb_wb_arbiter;

    localparam int DEPTH   = 2;
    localparam int CNT_MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        alu_valid = 1'b0, ld_valid = 1'b0, iss_valid = 1'b0;
    logic [4:0]  alu_rd = '0, ld_rd = '0, iss_rd = '0, raddr1 = '0, raddr2 = '0;
    logic [31:0] alu_data = '0, ld_data = '0;
    logic [2:0]  ld_funct3 = '0;
    logic [1:0]  ld_off = '0;
    logic        alu_ready, busy1, busy2, iss_full, sb_err, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef WB_COMMIT_CNT_EN
    logic [63:0] instret;
`endif

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .SB_CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .ld_funct3 (ld_funct3),
        .ld_off    (ld_off),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .busy1     (busy1),
        .busy2     (busy2),
        .iss_full  (iss_full),
        .sb_err    (sb_err),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata)
`ifdef WB_COMMIT_CNT_EN
        ,
        .instret   (instret)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;
    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wexp_t;
    typedef struct {
        bit          fl;
        bit          lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [2:0]  f3;
        logic [1:0]  off;
        bit          av;
        logic [4:0]  ard;
        logic [31:0] adata;
        bit          iv;
        logic [4:0]  ird;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } txn_t;

    res_t   mq[$];
    int     cnt[32];
    bit     m_err;
    longint m_instret;
    wexp_t  exp_q[$];
    wexp_t  lit_q[$];
    bit     mon_en = 1'b0;
    int     last_cyc;
    bit     last_acc;

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        longint v;
        v = longint'(w >> (8 * off));
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v -= 256;   end
            3'd1: begin v = v % 65536; if (v >= 32768) v -= 65536; end
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: ;
        endcase
        return v[31:0];
    endfunction

    function automatic txn_t idle_t();
        txn_t t;
        t = '{default: 0};
        t.r1 = 5'd7;
        t.r2 = 5'd3;
        return t;
    endfunction

    task automatic model_clear();
        mq.delete();
        foreach (cnt[i]) cnt[i] = 0;
        m_err = 0;
        m_instret = 0;
        exp_q.delete();
        lit_q.delete();
    endtask

    task automatic step(input txn_t t);
        bit   rdy, have;
        res_t s;
        @(negedge clk);
        flush = t.fl;      ld_valid = t.lv;   ld_rd = t.lrd;      ld_data = t.ldata;
        ld_funct3 = t.f3;  ld_off = t.off;    alu_valid = t.av;   alu_rd = t.ard;
        alu_data = t.adata; iss_valid = t.iv; iss_rd = t.ird;     raddr1 = t.r1;
        raddr2 = t.r2;
        #1;
        rdy = (mq.size() < DEPTH) || t.fl;
        check("alu_ready", alu_ready, rdy);
        check("busy1", busy1, (t.r1 != 0) && (cnt[t.r1] != 0));
        check("busy2", busy2, (t.r2 != 0) && (cnt[t.r2] != 0));
        check("iss_full", iss_full, cnt[t.ird] == CNT_MAX);
        check("sb_err", sb_err, m_err);
`ifdef WB_COMMIT_CNT_EN
        check("instret", instret, m_instret);
`endif
        last_cyc = cyc;
        last_acc = t.av && rdy && !t.fl;
        if (t.fl) begin
            mq.delete();
            foreach (cnt[i]) cnt[i] = 0;
        end else begin
            have = 0;
            if (t.lv) begin
                have = 1; s.rd = t.lrd; s.data = ref_load(t.ldata, t.f3, t.off);
            end else if (mq.size() > 0) begin
                have = 1; s = mq.pop_front();
            end
            if (have) begin
                m_instret++;
                if (s.rd != 0) exp_q.push_back('{cyc + 1, s.rd, s.data});
            end
            if (t.iv && t.ird != 0 && !(have && s.rd == t.ird)) begin
                if (cnt[t.ird] == CNT_MAX) m_err = 1; else cnt[t.ird]++;
            end
            if (have && s.rd != 0 && !(t.iv && t.ird == s.rd)) begin
                if (cnt[s.rd] == 0) m_err = 1; else cnt[s.rd]--;
            end
            if (last_acc) mq.push_back('{t.ard, t.adata});
        end
    endtask

    task automatic do_reset();
        mon_en = 0;
        @(negedge clk);
        rst = 1; flush = 0; alu_valid = 0; ld_valid = 0; iss_valid = 0;
        raddr1 = 5'd7; raddr2 = 5'd3;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy1", busy1, 0);
        check("rst_busy2", busy2, 0);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_sb_err", sb_err, 0);
`ifdef WB_COMMIT_CNT_EN
        check("rst_instret", instret, 0);
`endif
        model_clear();
        rst = 0;
        mon_en = 1;
    endtask

    // Monitor: each expected write must appear on exactly its cycle, nothing else may write.
    initial begin
        wexp_t w;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    w = exp_q.pop_front();
                    check("wb_we", we, 1);
                    if (we) begin
                        check("wb_waddr", waddr, w.addr);
                        check("wb_wdata", wdata, w.data);
                    end
                end else if (we) begin
                    check("spurious_we", we, 0);
                end
                if (lit_q.size() > 0 && lit_q[0].cyc == cyc) begin
                    w = lit_q.pop_front();
                    check("lit_we", we, 1);
                    check("lit_waddr", waddr, w.addr);
                    check("lit_wdata", wdata, w.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        txn_t t;
        do_reset();

        // ALU result rd=5, then a rd=0 result that must not write
        t = idle_t(); t.av = 1; t.ard = 5; t.adata = 32'h0000_1234; t.iv = 1; t.ird = 5;
        step(t);
        lit_q.push_back('{last_cyc + 2, 5'd5, 32'h0000_1234});
        t = idle_t(); t.av = 1; t.ard = 0; t.adata = 32'hDEAD_BEEF;
        step(t);
        repeat (3) step(idle_t());

        // Load extension cases, issue and commit in the same cycle
        begin
            logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
            logic [1:0]  offs[4] = '{2'd3, 2'd0, 2'd2, 2'd2};
            logic [31:0] lits[4] = '{32'hFFFF_FF80, 32'h0000_0001, 32'h0000_80FF, 32'hFFFF_80FF};
            for (int i = 0; i < 4; i++) begin
                t = idle_t(); t.lv = 1; t.lrd = 5'(10 + i); t.ldata = 32'h80FF_7F01;
                t.f3 = f3s[i]; t.off = offs[i]; t.iv = 1; t.ird = 5'(10 + i);
                step(t);
                lit_q.push_back('{last_cyc + 1, 5'(10 + i), lits[i]});
            end
        end
        step(idle_t());

        // Load and ALU in the same cycle: load first
        t = idle_t(); t.iv = 1; t.ird = 3; step(t);
        t = idle_t(); t.iv = 1; t.ird = 4; step(t);
        t = idle_t(); t.lv = 1; t.lrd = 3; t.ldata = 32'h0000_0033; t.f3 = 3'b010;
        t.av = 1; t.ard = 4; t.adata = 32'h0000_0044;
        step(t);
        lit_q.push_back('{last_cyc + 1, 5'd3, 32'h0000_0033});
        lit_q.push_back('{last_cyc + 2, 5'd4, 32'h0000_0044});
        repeat (2) step(idle_t());

        // Back-to-back loads fill the buffer; held ALU request waits for space
        for (int i = 0; i < 3; i++) begin
            t = idle_t(); t.lv = 1; t.lrd = 5'(11 + i); t.ldata = 32'(i); t.f3 = 3'b010;
            t.av = 1; t.ard = 5'(20 + i); t.adata = 32'h100 + 32'(i);
            t.iv = 1; t.ird = 5'(11 + i);
            step(t);
            if (last_acc && i == 2) break;
        end
        for (int i = 0; i < 6 && !last_acc; i++) begin
            t = idle_t(); t.av = 1; t.ard = 5'd22; t.adata = 32'h102;
            step(t);
        end
        repeat (4) step(idle_t());

        // Scoreboard on r7: busy through two commits, same-cycle issue+commit, saturation
        do_reset();
        for (int i = 0; i < 2; i++) begin
            t = idle_t(); t.iv = 1; t.ird = 7; step(t);
        end
        t = idle_t(); t.av = 1; t.ard = 7; t.adata = 32'h7; step(t);
        step(idle_t());
        step(idle_t());
        t = idle_t(); t.av = 1; t.ard = 7; t.adata = 32'h77; step(t);
        t = idle_t(); t.iv = 1; t.ird = 7; step(t);
        step(idle_t());
        for (int i = 0; i < 4; i++) begin
            t = idle_t(); t.iv = 1; t.ird = 7; step(t);
        end
        step(idle_t());

        // Flush with two ALU entries queued behind loads
        do_reset();
        for (int i = 0; i < 2; i++) begin
            t = idle_t(); t.r1 = 8; t.r2 = 9; t.iv = 1; t.ird = 5'(8 + i);
            t.lv = 1; t.lrd = 5'(1 + i); t.ldata = 32'hA0 + 32'(i); t.f3 = 3'b010;
            t.av = 1; t.ard = 5'(8 + i); t.adata = 32'hB0 + 32'(i);
            step(t);
        end
        t = idle_t(); t.r1 = 8; t.r2 = 9; t.fl = 1; t.lv = 1; t.lrd = 5'd6; t.ldata = 32'hEE;
        t.f3 = 3'b010; t.av = 1; t.ard = 5'd6; t.adata = 32'hFF;
        step(t);
        repeat (4) begin
            t = idle_t(); t.r1 = 8; t.r2 = 9; step(t);
        end

        // Random traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            t = idle_t();
            t.fl    = ($urandom_range(0, 29) == 0);
            t.lv    = ($urandom_range(0, 9) < 3);
            t.lrd   = 5'($urandom_range(0, 7));
            t.ldata = $urandom();
            t.f3    = 3'($urandom_range(0, 7));
            t.off   = 2'($urandom_range(0, 3));
            t.av    = ($urandom_range(0, 9) < 6);
            t.ard   = 5'($urandom_range(0, 7));
            t.adata = $urandom();
            t.iv    = ($urandom_range(0, 9) < 4);
            t.ird   = 5'($urandom_range(0, 7));
            t.r1    = 5'($urandom_range(0, 7));
            t.r2    = 5'($urandom_range(0, 7));
            step(t);
        end
        repeat (4) step(idle_t());
        @(negedge clk);
        #1;
        check("exp_drained", 64'(exp_q.size()), 0);
        check("lit_drained", 64'(lit_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
